// File: rtl/sc_pkg.sv
// Shared constants and types for the stochastic-computing datapath:
// operand width, stream length, Sobol direction vectors and SNG state.
package sc_pkg;

    localparam int WIDTH      = 6;
    localparam int STREAM_LEN = 1 << WIDTH;

    // Element [k] holds direction vector v_(k+1), so [0] is the MSB-weight vector.
    typedef logic [WIDTH-1:0][WIDTH-1:0] dirv_t;

    localparam dirv_t DIM1_V = {6'd1, 6'd2, 6'd4, 6'd8, 6'd16, 6'd32};
    localparam dirv_t DIM2_V = {6'd51, 6'd34, 6'd60, 6'd40, 6'd48, 6'd32};

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

endpackage

// File: rtl/sobol_seq_gen.sv
// One Sobol dimension in Gray-code form: each advance XORs in the direction
// vector selected by the lowest zero bit of the current index n.
module sobol_seq_gen
    import sc_pkg::*;
#(
    parameter dirv_t DIRV = DIM1_V
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             adv,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] x
);

    logic [WIDTH-1:0] step;

    // Scanning downward lets the lowest zero bit win; an all-ones n selects no vector.
    always_comb begin
        step = '0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            if (!n[k]) step = DIRV[k];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x <= '0;
        end else if (clr) begin
            x <= '0;
        end else if (adv) begin
            x <= x ^ step;
        end
    end

endmodule

// File: rtl/sobol_sng_bank.sv
// Bank of Sobol-driven stochastic number generators: latches N_OPS operands and
// emits one 64-bit stream each. Optional digital shift: define SNG_SCRAMBLE_EN.
module sobol_sng_bank #(
    parameter int WIDTH      = sc_pkg::WIDTH,
    parameter int N_OPS      = 8,
    parameter int STREAM_LEN = sc_pkg::STREAM_LEN
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_in,
    input  logic [N_OPS*WIDTH-1:0] num,
`ifdef SNG_SCRAMBLE_EN
    input  logic [WIDTH-1:0]       scramble,
`endif
    output logic                   busy,
    output logic                   bit_valid,
    output logic                   bit_first,
    output logic                   bit_last,
    output logic [N_OPS-1:0]       bits
);

    import sc_pkg::*;

    localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(STREAM_LEN - 1);

    state_t                 state;
    logic [WIDTH-1:0]       idx;
    logic [N_OPS*WIDTH-1:0] opnd;
    logic [WIDTH-1:0]       x1;
    logic [WIDTH-1:0]       x2;
    logic [WIDTH-1:0]       s1;
    logic [WIDTH-1:0]       s2;
    logic                   start;
    logic                   adv;

    function automatic logic above(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return a > b;
    endfunction

    assign start = (state == IDLE) && en_in;
    // The generators hold on the final index; the next start clears them anyway.
    assign adv   = (state == RUN) && (idx != LAST_IDX);

`ifdef SNG_SCRAMBLE_EN
    logic [WIDTH-1:0] scr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scr <= '0;
        end else if (start) begin
            scr <= scramble;
        end
    end

    assign s1 = x1 ^ scr;
    assign s2 = x2 ^ scr;
`else
    assign s1 = x1;
    assign s2 = x2;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            idx   <= '0;
            opnd  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en_in) begin
                        opnd  <= num;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        state <= IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sobol_seq_gen #(.DIRV(DIM1_V)) u_dim1 (
        .clk (clk),
        .rst (rst),
        .clr (start),
        .adv (adv),
        .n   (idx),
        .x   (x1)
    );

    sobol_seq_gen #(.DIRV(DIM2_V)) u_dim2 (
        .clk (clk),
        .rst (rst),
        .clr (start),
        .adv (adv),
        .n   (idx),
        .x   (x2)
    );

    // Operand k=0 is num1 (odd) and uses dimension 1; pairs stay decorrelated.
    always_comb begin
        bits = '0;
        if (state == RUN) begin
            for (int k = 0; k < N_OPS; k++) begin
                bits[k] = above(opnd[k*WIDTH +: WIDTH], (k % 2 == 0) ? s1 : s2);
            end
        end
    end

    assign busy      = (state == RUN);
    assign bit_valid = (state == RUN);
    assign bit_first = (state == RUN) && (idx == '0);
    assign bit_last  = (state == RUN) && (idx == LAST_IDX);

endmodule

// File: tb/tb_sobol_sng_bank.sv
// Scoreboard bench for sobol_sng_bank: Sobol values come from the closed-form
// Gray-code sum of direction vectors; a negedge monitor pops and compares.
module tb_sobol_sng_bank;

    localparam int W = 6;
    localparam int N = 8;
    localparam int L = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic           en_in;
    logic [N*W-1:0] num;
    logic           busy;
    logic           bit_valid;
    logic           bit_first;
    logic           bit_last;
    logic [N-1:0]   bits;
`ifdef SNG_SCRAMBLE_EN
    logic [W-1:0]   scramble;
`endif

    always #5 clk = ~clk;

    sobol_sng_bank dut (
        .clk       (clk),
        .rst       (rst),
        .en_in     (en_in),
        .num       (num),
`ifdef SNG_SCRAMBLE_EN
        .scramble  (scramble),
`endif
        .busy      (busy),
        .bit_valid (bit_valid),
        .bit_first (bit_first),
        .bit_last  (bit_last),
        .bits      (bits)
    );

    typedef struct {
        logic [N-1:0]   bits;
        logic           first;
        logic           last;
        logic [N*W-1:0] ops;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    int v1[6] = '{32, 16, 8, 4, 2, 1};
    int m2[6] = '{1, 3, 5, 15, 17, 51};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // x_i = XOR of v_k over the set bits of gray(i)
    function automatic int sobol(input int dim, input int i);
        int g;
        int x;
        g = i ^ (i >> 1);
        x = 0;
        for (int k = 0; k < 6; k++) begin
            if (((g >> k) & 1) == 1) x = x ^ ((dim == 1) ? v1[k] : (m2[k] << (5 - k)));
        end
        return x;
    endfunction

    function automatic logic [N-1:0] model_bits(input logic [N*W-1:0] ops, input int i, input int scr);
        logic [N-1:0] b;
        for (int k = 0; k < N; k++) begin
            int x;
            x = sobol((k % 2 == 0) ? 1 : 2, i) ^ scr;
            b[k] = (int'(ops[k*W +: W]) > x);
        end
        return b;
    endfunction

    task automatic push_set(input logic [N*W-1:0] ops, input int scr);
        exp_t e;
        for (int i = 0; i < L; i++) begin
            e.bits  = model_bits(ops, i, scr);
            e.first = (i == 0);
            e.last  = (i == L - 1);
            e.ops   = ops;
            q.push_back(e);
        end
    endtask

    // Monitor: pops one expected beat per valid cycle and checks stream ones counts.
    int cnt[N];
    always @(negedge clk) begin : monitor
        exp_t e;
        if (bit_valid) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid actual=1 required=0 at %0t", $time);
            end else begin
                e = q.pop_front();
                chk("bits", bits, e.bits);
                chk("first_last_busy", {bit_first, bit_last, busy}, {e.first, e.last, 1'b1});
                if (e.first) begin
                    for (int k = 0; k < N; k++) cnt[k] = 0;
                end
                for (int k = 0; k < N; k++) cnt[k] += bits[k];
                if (e.last) begin
                    for (int k = 0; k < N; k++) chk("ones_count", cnt[k], e.ops[k*W +: W]);
                end
            end
        end
    end

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (busy) begin
            bad++;
            total++;
            $display("FAIL idle_timeout actual=busy required=idle at %0t", $time);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    endtask

    task automatic start_set(input logic [N*W-1:0] ops, input int scr);
        wait_idle();
        num = ops;
`ifdef SNG_SCRAMBLE_EN
        scramble = W'(scr);
`endif
        push_set(ops, scr);
        en_in = 1'b1;
        @(posedge clk);
        #1;
        en_in = 1'b0;
        chk("latency_valid", bit_valid, 1);
    endtask

    task automatic drain();
        wait_idle();
        chk("valid_low_after_last", {busy, bit_valid}, 2'b00);
        chk("queue_drained", q.size(), 0);
    endtask

    function automatic logic [N*W-1:0] rand_ops();
        logic [N*W-1:0] r;
        for (int k = 0; k < N; k++) r[k*W +: W] = W'($urandom_range(0, 63));
        return r;
    endfunction

    initial begin
        int p1[5] = '{1, 1, 0, 1, 1};
        int p2[5] = '{1, 1, 1, 0, 1};
        logic [N*W-1:0] ops;

        rst   = 1'b0;
        en_in = 1'b0;
        num   = '0;
`ifdef SNG_SCRAMBLE_EN
        scramble = '0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy, bit_valid, bit_first, bit_last, bits}, 0);
        rst = 1'b1;

        // all operands 32
        start_set({N{6'd32}}, 0);
        drain();

        // operand 40: first five bits of each dimension
        start_set({N{6'd40}}, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("seq_dim1_bit0", bits[0], p1[i]);
            chk("seq_dim2_bit1", bits[1], p2[i]);
        end
        drain();

        // boundary operands 0 and 63
        start_set({6'd63, 6'd0, 6'd63, 6'd0, 6'd0, 6'd63, 6'd0, 6'd63}, 0);
        drain();

        // en_in during RUN with other operands is ignored
        ops = rand_ops();
        start_set(ops, 0);
        repeat (10) @(posedge clk);
        #1;
        num   = ~ops;
        en_in = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        en_in = 1'b0;
        drain();

        // async reset at idx 20, then restart from x_0
        start_set(rand_ops(), 0);
        repeat (20) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("reset_mid_run", {busy, bit_valid, bit_first, bit_last, bits}, 0);
        q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        start_set({N{6'd40}}, 0);
        chk("restart_first", bit_first, 1);
        drain();

`ifdef SNG_SCRAMBLE_EN
        begin
            logic diff;
            diff = 1'b0;
            start_set({N{6'd17}}, 'h2A);
            for (int i = 0; i < L; i++) begin
                @(negedge clk);
                if (bits !== model_bits({N{6'd17}}, i, 0)) diff = 1'b1;
            end
            chk("scramble_differs", diff, 1);
            drain();
        end
`endif

        // back-to-back random operand sets
        for (int s = 0; s < 1000; s++) begin
`ifdef SNG_SCRAMBLE_EN
            start_set(rand_ops(), int'($urandom_range(0, 63)));
`else
            start_set(rand_ops(), 0);
`endif
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sobol_sng_bank.md
Name: sobol_sng_bank

Overview:
Upstream stage of the stochastic-computing dot-product datapath. It latches eight 6-bit unipolar operands (value/64) on a start handshake. It then emits eight parallel 64-cycle bitstreams, one bit per operand per cycle. Each stream is produced by comparing its operand against a low-discrepancy Sobol sequence. Odd operands (num1,3,5,7) use Sobol dimension 1 and even operands (num2,4,6,8) use dimension 2, so the downstream AND-multiply of each pair stays decorrelated. Over one stream, the count of ones equals the operand exactly.

Parameters:
WIDTH, 6, operand and sequence width in bits
N_OPS, 8, number of operands and streams (must be even)
STREAM_LEN, 64, bits per stream (fixed at 2**WIDTH)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
en_in  in  1  start request; sampled only while idle
num  in  N_OPS*WIDTH  packed operands; operand k is at bits [k*WIDTH +: WIDTH], k=0 is num1
busy  out  1  high from the accepting edge until the last stream bit has been emitted
bit_valid  out  1  the bits output is valid this cycle
bit_first  out  1  marks stream index 0
bit_last  out  1  marks stream index 63
bits  out  N_OPS  bit k = (opnd_k > sobol_dim(k)[idx])

Behaviour:
- Reset (rst=0, async): state IDLE, idx=0, both Sobol registers=0, operand latches=0. All outputs are 0.
- States:
  - IDLE: busy=0. When en_in=1 at a posedge, latch num, clear idx and the Sobol registers, go to RUN.
  - RUN: busy=1, bit_valid=1 for exactly 64 consecutive cycles, starting the cycle after acceptance (latency 1).
  - RUN exit: when idx==63, assert bit_last and return to IDLE at the next edge. busy falls together with bit_valid.
- en_in while RUN is ignored. Operands are not re-latched mid-stream.
- Back-to-back operation: en_in high in the first IDLE cycle is accepted. The minimum period is therefore 65 cycles per operand set.
- Sobol generation (Gray-code form):
  - Initial values: x_0=0.
  - Update: x_{n+1} = x_n XOR v_c, where c is the 1-based index of the lowest zero bit of n.
  - Dim1 direction vectors: v = 32,16,8,4,2,1 (bit-reversed counter).
  - Dim2 direction vectors: m = 1,3,5,15,17,51, v_k = m_k << (6-k), giving 32,48,40,60,34,51.
- Each dimension is a permutation of 0..63 over one stream. The ones count per stream therefore equals the operand, for operand values 0..63.
- Comparison is unsigned and strict (>). Operand 0 produces an all-zero stream; operand 63 produces 63 ones.
- idx is a 6-bit counter and wraps 63→0 only when the stream ends. No partial streams are emitted.
- Reset mid-RUN: outputs clear immediately and the stream is abandoned. The next en_in after reset release restarts from x_0.

Optional Feature:
SNG_SCRAMBLE_EN
- With it defined: an extra input port `scramble` (WIDTH bits) is latched at acceptance. Every Sobol value is XORed with it before comparison. This is a digital shift: the permutation property holds, so ones counts are unchanged but bit ordering differs.
- Without it: no port and no XOR; the sequences are exactly as above.

Decomposition:
- Package sc_pkg:
  - WIDTH and STREAM_LEN constants
  - dim1/dim2 direction-vector constant arrays
  - state enum {IDLE, RUN}
- Sub-module sobol_seq_gen, instantiated twice (once per dimension):
  - parameterized by its direction-vector array
  - inputs: clr, adv, n
  - output: x
- Comparators and the FSM live in sobol_sng_bank.

Test Plan:
- Reset, then en_in=1 with all operands 32 → bit_valid high for exactly 64 cycles starting 1 cycle after acceptance. Each stream has 32 ones. busy and bit_valid fall after bit_last.
- Sequence check: dim1 x = 0,32,48,16,24,… and dim2 x = 0,32,16,48,24,… for the first 5 cycles. With operand 40, bit0 = 1,1,0,1,1.
- Operands 0 and 63 → counts 0 and 63 respectively. Random operands over 1000 sets → per-stream count == operand every time.
- en_in pulsed during RUN with different num → ignored; counts match the originally latched values.
- rst asserted at idx=20 → outputs 0 asynchronously. After release, en_in restarts the stream at x=0, with bit_first on the first valid cycle.
- SNG_SCRAMBLE_EN defined, scramble=6'h2A, operands 17 → counts still 17. Bit pattern differs from the unscrambled run.
